// File: rtl/sync_pkg.sv
// Shared types and helpers for the multi-channel level synchronizer/filter.
// Edge-mode encoding is {fall_en, rise_en}.
package sync_pkg;

   typedef enum logic [1:0] {
      EDGE_NONE = 2'b00,
      EDGE_RISE = 2'b01,
      EDGE_FALL = 2'b10,
      EDGE_BOTH = 2'b11
   } edge_mode_e;

   // Counter must be able to hold FILTER_CNT-1 and still fit for FILTER_CNT=1.
   function automatic int cnt_width(input int filter_cnt);
      return $clog2(filter_cnt + 1);
   endfunction

endpackage

// File: rtl/sync_filter_ch.sv
// One channel: SYNC_STAGE-flop synchronizer, FILTER_CNT glitch filter, rise/fall pulses.
// Latency din->dout SYNC_STAGE+FILTER_CNT cycles (+1 sampling); no backpressure, always accepts.
module sync_filter_ch
   import sync_pkg::*;
#(
   parameter int   SYNC_STAGE = 3,
   parameter int   FILTER_CNT = 4,
   parameter logic INIT_BIT   = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall
);

   localparam int CW = cnt_width(FILTER_CNT);

   (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGE-1:0] r_sync;
   logic [CW-1:0] r_cnt;
   logic          r_dout;
   logic          r_rise;
   logic          r_fall;
   logic          w_s;

   assign w_s = r_sync[SYNC_STAGE-1];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync <= {SYNC_STAGE{INIT_BIT}};
         r_cnt  <= '0;
         r_dout <= INIT_BIT;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGE-2:0], din};
         r_rise <= 1'b0;
         r_fall <= 1'b0;
         // Any sample matching the current level restarts the qualification run.
         if (w_s == r_dout) begin
            r_cnt <= '0;
         end else if (r_cnt == CW'(FILTER_CNT - 1)) begin
            r_dout <= w_s;
            r_cnt  <= '0;
            r_rise <= w_s;
            r_fall <= ~w_s;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign dout = r_dout;
   assign rise = r_rise;
   assign fall = r_fall;

endmodule

// File: rtl/data_sync_filter.sv
// Multi-channel synchronizer + glitch filter with edge-qualified sticky events and maskable irq.
// Sticky bit one cycle after the edge pulse, irq combinational from registers; no backpressure.
module data_sync_filter
   import sync_pkg::*;
#(
   parameter int                NUM_CH     = 8,
   parameter int                SYNC_STAGE = 3,
   parameter int                FILTER_CNT = 4,
   parameter logic [NUM_CH-1:0] INIT_VAL   = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_CH-1:0]     din,
   input  logic [2*NUM_CH-1:0]   edge_mode,
   input  logic [NUM_CH-1:0]     evt_clr,
   input  logic [NUM_CH-1:0]     irq_en,
   output logic [NUM_CH-1:0]     dout,
   output logic [NUM_CH-1:0]     rise,
   output logic [NUM_CH-1:0]     fall,
   output logic [NUM_CH-1:0]     evt_sticky,
   output logic                  irq
);

   logic [NUM_CH-1:0] w_evt;
   logic [NUM_CH-1:0] r_sticky;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      edge_mode_e w_mode;

      sync_filter_ch #(
         .SYNC_STAGE (SYNC_STAGE),
         .FILTER_CNT (FILTER_CNT),
         .INIT_BIT   (INIT_VAL[i])
      ) u_ch (
         .clk   (clk),
         .reset (reset),
         .din   (din[i]),
         .dout  (dout[i]),
         .rise  (rise[i]),
         .fall  (fall[i])
      );

      assign w_mode   = edge_mode_e'(edge_mode[2*i +: 2]);
      assign w_evt[i] = (rise[i] & ((w_mode == EDGE_RISE) || (w_mode == EDGE_BOTH))) |
                        (fall[i] & ((w_mode == EDGE_FALL) || (w_mode == EDGE_BOTH)));
   end

   // A new event overrides a clear arriving in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sticky <= '0;
      end else begin
         r_sticky <= w_evt | (r_sticky & ~evt_clr);
      end
   end

   assign evt_sticky = r_sticky;
   assign irq        = |(r_sticky & irq_en);

endmodule

// File: tb/tb_data_sync_filter.sv
// Directed and randomized checks of data_sync_filter against a sample-window reference model.
module tb_data_sync_filter;

   localparam int NC = 8;
   localparam int SS = 3;
   localparam int FC = 4;
   localparam logic [NC-1:0] INIT = 8'h0F;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [NC-1:0] din = INIT;
   logic [2*NC-1:0] edge_mode = '0;
   logic [NC-1:0] evt_clr = '0;
   logic [NC-1:0] irq_en = '0;
   logic [NC-1:0] dout, rise, fall, evt_sticky;
   logic          irq;

   int tests = 0;
   int fails = 0;

   // Reference model: din delayed by SS cycles, then the level flips once the
   // last FC delayed samples all disagree with it.
   logic [NC-1:0] dly [SS];
   logic [NC-1:0] win [FC];
   logic [NC-1:0] m_dout, m_rise, m_fall, m_sticky;
   bit            m_valid = 0;

   data_sync_filter #(
      .NUM_CH     (NC),
      .SYNC_STAGE (SS),
      .FILTER_CNT (FC),
      .INIT_VAL   (INIT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .din        (din),
      .edge_mode  (edge_mode),
      .evt_clr    (evt_clr),
      .irq_en     (irq_en),
      .dout       (dout),
      .rise       (rise),
      .fall       (fall),
      .evt_sticky (evt_sticky),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      logic [NC-1:0] evt, s, flip;
      @(posedge clk);
      if (reset) begin
         for (int k = 0; k < SS; k++) dly[k] = INIT;
         for (int k = 0; k < FC; k++) win[k] = INIT;
         m_dout   = INIT;
         m_rise   = '0;
         m_fall   = '0;
         m_sticky = '0;
         m_valid  = 1;
      end else begin
         for (int i = 0; i < NC; i++)
            evt[i] = (m_rise[i] & edge_mode[2*i]) | (m_fall[i] & edge_mode[2*i+1]);
         m_sticky = evt | (m_sticky & ~evt_clr);
         s = dly[SS-1];
         for (int k = FC-1; k > 0; k--) win[k] = win[k-1];
         win[0] = s;
         flip = '1;
         for (int k = 0; k < FC; k++) flip &= (win[k] ^ m_dout);
         m_rise = flip & ~m_dout;
         m_fall = flip & m_dout;
         m_dout = m_dout ^ flip;
         for (int k = SS-1; k > 0; k--) dly[k] = dly[k-1];
         dly[0] = din;
      end
      #1;
      if (m_valid) begin
         chk("model_dout", 32'(dout), 32'(m_dout));
         chk("model_rise", 32'(rise), 32'(m_rise));
         chk("model_fall", 32'(fall), 32'(m_fall));
         chk("model_sticky", 32'(evt_sticky), 32'(m_sticky));
         chk("model_irq", 32'(irq), 32'(|(m_sticky & irq_en)));
      end
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic clear_all();
      evt_clr = '1;
      tick();
      evt_clr = '0;
   endtask

   initial begin
      int  n;
      bit  seen;

      // Reset state and 20 quiet cycles after release
      ticks(3);
      reset = 1'b0;
      seen = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (dout !== INIT || rise !== 0 || fall !== 0 || irq !== 0) seen = 1;
      end
      chk("reset_quiet", 32'(seen), 32'd0);
      chk("reset_dout", 32'(dout), 32'h0F);

      // Bring every channel low, then measure ch0 rise latency
      din = '0;
      ticks(12);
      chk("all_low", 32'(dout), 32'h00);
      clear_all();
      edge_mode[1:0] = 2'b01;
      irq_en[0] = 1'b1;
      din[0] = 1'b1;
      n = 0;
      while (dout[0] !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk("ch0_latency_ok", 32'(n >= 7 && n <= 8), 32'd1);
      chk("ch0_rise_pulse", 32'(rise[0]), 32'd1);
      tick();
      chk("ch0_rise_single", 32'(rise[0]), 32'd0);
      chk("ch0_sticky", 32'(evt_sticky[0]), 32'd1);
      chk("ch0_irq", 32'(irq), 32'd1);
      irq_en[0] = 1'b0;
      clear_all();

      // ch1: 3-cycle glitch rejected, 4-cycle pulse accepted
      din[1] = 1'b1;
      ticks(3);
      din[1] = 1'b0;
      seen = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (dout[1] !== 1'b0 || rise[1] !== 1'b0) seen = 1;
      end
      chk("ch1_glitch_rejected", 32'(seen), 32'd0);
      din[1] = 1'b1;
      ticks(4);
      din[1] = 1'b0;
      seen = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (rise[1] === 1'b1) seen = 1;
      end
      chk("ch1_pulse_accepted", 32'(seen), 32'd1);

      // ch2: fall-only qualification
      edge_mode[5:4] = 2'b10;
      din[2] = 1'b1;
      n = 0;
      while (rise[2] !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk("ch2_rise_seen", 32'(rise[2]), 32'd1);
      tick();
      chk("ch2_no_sticky_on_rise", 32'(evt_sticky[2]), 32'd0);
      din[2] = 1'b0;
      n = 0;
      while (fall[2] !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk("ch2_fall_seen", 32'(fall[2]), 32'd1);
      tick();
      chk("ch2_sticky_on_fall", 32'(evt_sticky[2]), 32'd1);

      // ch3: set wins over simultaneous clear, then clear drops irq
      edge_mode[7:6] = 2'b01;
      irq_en = 8'h08;
      din[3] = 1'b1;
      n = 0;
      while (rise[3] !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk("ch3_rise_seen", 32'(rise[3]), 32'd1);
      evt_clr[3] = 1'b1;
      tick();
      chk("ch3_set_wins", 32'(evt_sticky[3]), 32'd1);
      chk("ch3_irq_set", 32'(irq), 32'd1);
      tick();
      chk("ch3_cleared", 32'(evt_sticky[3]), 32'd0);
      chk("ch3_irq_drop", 32'(irq), 32'd0);
      evt_clr = '0;
      irq_en = '0;

      // Reset two cycles into a filter count on ch4
      din = '0;
      ticks(12);
      clear_all();
      din[4] = 1'b1;
      ticks(5);
      reset = 1'b1;
      din = INIT;
      tick();
      chk("midreset_dout", 32'(dout), 32'h0F);
      chk("midreset_edges", 32'(rise | fall), 32'd0);
      chk("midreset_sticky", 32'(evt_sticky), 32'd0);
      reset = 1'b0;
      seen = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (rise !== 0 || fall !== 0 || dout !== INIT) seen = 1;
      end
      chk("midreset_quiet", 32'(seen), 32'd0);

      // Random soak
      edge_mode = 16'(($urandom));
      irq_en = 8'($urandom);
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < NC; i++)
            if ($urandom_range(0, 5) == 0) din[i] = ~din[i];
         evt_clr = 8'($urandom & $urandom & $urandom);
         if ($urandom_range(0, 49) == 0) edge_mode = 16'($urandom);
         if ($urandom_range(0, 49) == 0) irq_en = 8'($urandom);
         reset = ($urandom_range(0, 499) == 0);
         tick();
      end
      reset = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
